// File: rtl/wb_retire_queue.sv
// In-order writeback/retire queue between MEM and the register file.
// Commits GPR writes and HI/LO, exposes youngest-match bypass over queued entries.
module wb_retire_queue #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic [PC_W-1:0]             in_pc_i,
    input  logic                        in_rf_we_i,
    input  logic [ADDR_W-1:0]           in_rf_waddr_i,
    input  logic [DATA_W-1:0]           in_rf_wdata_i,
    input  logic                        in_hi_we_i,
    input  logic [DATA_W-1:0]           in_hi_wdata_i,
    input  logic                        in_lo_we_i,
    input  logic [DATA_W-1:0]           in_lo_wdata_i,
    input  logic                        rf_hold_i,
    output logic                        rf_we_o,
    output logic [ADDR_W-1:0]           rf_waddr_o,
    output logic [DATA_W-1:0]           rf_wdata_o,
    output logic [DATA_W-1:0]           hi_q_o,
    output logic [DATA_W-1:0]           lo_q_o,
    input  logic [ADDR_W-1:0]           fwd_raddr_i,
    output logic                        fwd_hit_o,
    output logic [DATA_W-1:0]           fwd_rdata_o,
    output logic [DATA_W-1:0]           fwd_hi_o,
    output logic [DATA_W-1:0]           fwd_lo_o,
    output logic [PC_W-1:0]             debug_wb_pc_o,
    output logic [3:0]                  debug_wb_rf_wen_o,
    output logic [ADDR_W-1:0]           debug_wb_rf_wnum_o,
    output logic [DATA_W-1:0]           debug_wb_rf_wdata_o,
    output logic [31:0]                 retire_cnt_o,
    output logic [$clog2(DEPTH):0]      occupancy_o
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              rf_we;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] wdata;
        logic              hi_we;
        logic [DATA_W-1:0] hi_wdata;
        logic              lo_we;
        logic [DATA_W-1:0] lo_wdata;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            in_entry;
    entry_t            head;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [31:0]       retire_cnt_q, retire_cnt_d;
    logic              accept;
    logic              retire;

    assign in_entry = '{
        pc:       in_pc_i,
        rf_we:    in_rf_we_i,
        waddr:    in_rf_waddr_i,
        wdata:    in_rf_wdata_i,
        hi_we:    in_hi_we_i,
        hi_wdata: in_hi_wdata_i,
        lo_we:    in_lo_we_i,
        lo_wdata: in_lo_wdata_i
    };

    // No pass-through when full: readiness looks at the registered count only.
    assign in_ready_o = (count_q < CntW'(DEPTH)) && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign retire     = (count_q != '0) && !rf_hold_i && !flush_i;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        hi_d         = hi_q;
        lo_d         = lo_q;
        retire_cnt_d = retire_cnt_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (accept) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (retire) begin
                rd_ptr_d     = rd_ptr_q + PtrW'(1);
                retire_cnt_d = retire_cnt_q + 32'd1;
                if (head.hi_we) hi_d = head.hi_wdata;
                if (head.lo_we) lo_d = head.lo_wdata;
            end
            if (accept && !retire) begin
                count_d = count_q + CntW'(1);
            end else if (!accept && retire) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hi_q         <= '0;
            lo_q         <= '0;
            retire_cnt_q <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hi_q         <= hi_d;
            lo_q         <= lo_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    // Entry payload needs no reset; validity is tracked by count_q.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    always_comb begin
        rf_we_o    = retire && head.rf_we && (head.waddr != '0);
        rf_waddr_o = retire ? head.waddr : '0;
        rf_wdata_o = retire ? head.wdata : '0;
    end

    assign debug_wb_pc_o       = retire ? head.pc : '0;
    assign debug_wb_rf_wen_o   = {4{rf_we_o}};
    assign debug_wb_rf_wnum_o  = rf_waddr_o;
    assign debug_wb_rf_wdata_o = rf_wdata_o;
    assign hi_q_o              = hi_q;
    assign lo_q_o              = lo_q;
    assign retire_cnt_o        = retire_cnt_q;
    assign occupancy_o         = count_q;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        logic [PtrW-1:0] idx;
        idx         = '0;
        fwd_hit_o   = 1'b0;
        fwd_rdata_o = '0;
        fwd_hi_o    = hi_q;
        fwd_lo_o    = lo_q;
        for (int i = 0; i < int'(DEPTH); i++) begin
            idx = rd_ptr_q + PtrW'(i);
            if (CntW'(i) < count_q) begin
                if (mem_q[idx].rf_we && (mem_q[idx].waddr == fwd_raddr_i) &&
                    (fwd_raddr_i != '0)) begin
                    fwd_hit_o   = 1'b1;
                    fwd_rdata_o = mem_q[idx].wdata;
                end
                if (mem_q[idx].hi_we) fwd_hi_o = mem_q[idx].hi_wdata;
                if (mem_q[idx].lo_we) fwd_lo_o = mem_q[idx].lo_wdata;
            end
        end
    end

endmodule

// File: tb/tb_wb_retire_queue.sv
// Self-checking bench for wb_retire_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_wb_retire_queue;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        hi_we;
        logic [31:0] hi;
        logic        lo_we;
        logic [31:0] lo;
    } ent_t;

    logic        clk, rst, flush, in_valid, in_ready;
    logic [31:0] in_pc, in_rf_wdata, in_hi_wdata, in_lo_wdata;
    logic        in_rf_we, in_hi_we, in_lo_we, rf_hold;
    logic [4:0]  in_rf_waddr, fwd_raddr;
    logic        rf_we, fwd_hit;
    logic [4:0]  rf_waddr, dbg_wnum;
    logic [31:0] rf_wdata, hi_q, lo_q, fwd_rdata, fwd_hi, fwd_lo;
    logic [31:0] dbg_pc, dbg_wdata, retire_cnt;
    logic [3:0]  dbg_wen;
    logic [1:0]  occupancy;

    int tests = 0;
    int fails = 0;

    ent_t        q[$];
    logic [31:0] m_hi, m_lo, m_cnt;

    wb_retire_queue #(.DATA_W(32), .ADDR_W(5), .PC_W(32), .DEPTH(DEPTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush_i             (flush),
        .in_valid_i          (in_valid),
        .in_ready_o          (in_ready),
        .in_pc_i             (in_pc),
        .in_rf_we_i          (in_rf_we),
        .in_rf_waddr_i       (in_rf_waddr),
        .in_rf_wdata_i       (in_rf_wdata),
        .in_hi_we_i          (in_hi_we),
        .in_hi_wdata_i       (in_hi_wdata),
        .in_lo_we_i          (in_lo_we),
        .in_lo_wdata_i       (in_lo_wdata),
        .rf_hold_i           (rf_hold),
        .rf_we_o             (rf_we),
        .rf_waddr_o          (rf_waddr),
        .rf_wdata_o          (rf_wdata),
        .hi_q_o              (hi_q),
        .lo_q_o              (lo_q),
        .fwd_raddr_i         (fwd_raddr),
        .fwd_hit_o           (fwd_hit),
        .fwd_rdata_o         (fwd_rdata),
        .fwd_hi_o            (fwd_hi),
        .fwd_lo_o            (fwd_lo),
        .debug_wb_pc_o       (dbg_pc),
        .debug_wb_rf_wen_o   (dbg_wen),
        .debug_wb_rf_wnum_o  (dbg_wnum),
        .debug_wb_rf_wdata_o (dbg_wdata),
        .retire_cnt_o        (retire_cnt),
        .occupancy_o         (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit m_retire();
        return (q.size() != 0) && !rf_hold && !flush;
    endfunction

    function automatic logic m_rf_we();
        if (!m_retire()) return 1'b0;
        return q[0].rf_we && (q[0].waddr != 5'd0);
    endfunction

    function automatic logic [31:0] m_fwd_rdata(input logic [4:0] a, output logic hit);
        hit = 1'b0;
        if (a == 5'd0) return 32'd0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].rf_we && q[i].waddr == a) begin
                hit = 1'b1;
                return q[i].wdata;
            end
        end
        return 32'd0;
    endfunction

    function automatic logic [31:0] m_fwd_hi();
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].hi_we) return q[i].hi;
        return m_hi;
    endfunction

    function automatic logic [31:0] m_fwd_lo();
        for (int i = q.size() - 1; i >= 0; i--) if (q[i].lo_we) return q[i].lo;
        return m_lo;
    endfunction

    // Advance one clock, updating the model from the inputs present before the edge.
    task automatic tick();
        bit   rdy, ret, acc;
        ent_t e, h;
        rdy = (q.size() < DEPTH) && !flush;
        ret = m_retire();
        acc = in_valid && rdy;
        e = '{pc: in_pc, rf_we: in_rf_we, waddr: in_rf_waddr, wdata: in_rf_wdata,
              hi_we: in_hi_we, hi: in_hi_wdata, lo_we: in_lo_we, lo: in_lo_wdata};
        @(posedge clk);
        if (rst) begin
            q.delete();
            m_hi = 0; m_lo = 0; m_cnt = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (ret) begin
                h = q.pop_front();
                if (h.hi_we) m_hi = h.hi;
                if (h.lo_we) m_lo = h.lo;
                m_cnt = m_cnt + 1;
            end
            if (acc) q.push_back(e);
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic we,
                         input logic [4:0] a, input logic [31:0] d, input logic hwe,
                         input logic [31:0] hd, input logic lwe, input logic [31:0] ld);
        in_valid = v; in_pc = pc; in_rf_we = we; in_rf_waddr = a; in_rf_wdata = d;
        in_hi_we = hwe; in_hi_wdata = hd; in_lo_we = lwe; in_lo_wdata = ld;
    endtask

    task automatic idle_in();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; rf_hold = 1'b0; fwd_raddr = 5'd0;
        idle_in();
        tick(); tick();
        rst = 1'b0;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (occupancy !== 2'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
        tests++; if (rf_we !== 1'b0 || dbg_pc !== 32'd0 || dbg_wen !== 4'd0) begin
            fails++; $display("FAIL reset_retire_outs: we=%b pc=%h wen=%h want 0", rf_we, dbg_pc, dbg_wen); end
        tests++; if (hi_q !== 32'd0 || lo_q !== 32'd0 || retire_cnt !== 32'd0) begin
            fails++; $display("FAIL reset_regs: hi=%h lo=%h cnt=%0d want 0", hi_q, lo_q, retire_cnt); end
        tests++; if (fwd_hit !== 1'b0 || fwd_rdata !== 32'd0) begin
            fails++; $display("FAIL reset_fwd: hit=%b data=%h want 0", fwd_hit, fwd_rdata); end
    endtask

    task automatic test_basic();
        drive(1'b1, 32'hBFC0_0000, 1'b1, 5'd3, 32'h1234, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        idle_in();
        #1;
        tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h1234) begin
            fails++; $display("FAIL basic_rf: we=%b a=%0d d=%h want 1 3 1234", rf_we, rf_waddr, rf_wdata); end
        tests++; if (dbg_wen !== 4'hF || dbg_pc !== 32'hBFC0_0000 || dbg_wnum !== 5'd3 ||
                     dbg_wdata !== 32'h1234) begin
            fails++; $display("FAIL basic_debug: wen=%h pc=%h num=%0d d=%h want F bfc00000 3 1234",
                              dbg_wen, dbg_pc, dbg_wnum, dbg_wdata); end
        tick();
        tests++; if (retire_cnt !== 32'd1 || occupancy !== 2'd0) begin
            fails++; $display("FAIL basic_cnt: cnt=%0d occ=%0d want 1 0", retire_cnt, occupancy); end
    endtask

    task automatic test_backpressure();
        rf_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 32'h100 + 32'(k * 4), 1'b1, 5'(10 + k), 32'hA0 + 32'(k), 1'b0, 32'd0, 1'b0, 32'd0);
            tick();
        end
        idle_in();
        #1;
        tests++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin
            fails++; $display("FAIL bp_full: ready=%b occ=%0d want 0 2", in_ready, occupancy); end
        tests++; if (rf_we !== 1'b0 || dbg_pc !== 32'd0) begin
            fails++; $display("FAIL bp_held_outs: we=%b pc=%h want 0 0", rf_we, dbg_pc); end
        rf_hold = 1'b0;
        #1;
        tests++; if (rf_wdata !== 32'hA0 || dbg_pc !== 32'h100) begin
            fails++; $display("FAIL bp_first: d=%h pc=%h want a0 100", rf_wdata, dbg_pc); end
        tick();
        tests++; if (rf_wdata !== 32'hA1 || dbg_pc !== 32'h104 || in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_second: d=%h pc=%h ready=%b want a1 104 1", rf_wdata, dbg_pc, in_ready); end
        tick();
        tests++; if (occupancy !== 2'd0 || rf_we !== 1'b0) begin
            fails++; $display("FAIL bp_drained: occ=%0d we=%b want 0 0", occupancy, rf_we); end
    endtask

    task automatic test_fwd();
        rf_hold = 1'b1;
        drive(1'b1, 32'h200, 1'b1, 5'd5, 32'hA, 1'b0, 32'd0, 1'b0, 32'd0); tick();
        drive(1'b1, 32'h204, 1'b1, 5'd5, 32'hB, 1'b0, 32'd0, 1'b0, 32'd0);
        fwd_raddr = 5'd5;
        #1;
        tests++; if (fwd_hit !== 1'b1 || fwd_rdata !== 32'hA) begin
            fails++; $display("FAIL fwd_input_invisible: hit=%b d=%h want 1 a", fwd_hit, fwd_rdata); end
        tick();
        idle_in();
        #1;
        tests++; if (fwd_hit !== 1'b1 || fwd_rdata !== 32'hB) begin
            fails++; $display("FAIL fwd_youngest: hit=%b d=%h want 1 b", fwd_hit, fwd_rdata); end
        fwd_raddr = 5'd0; #1;
        tests++; if (fwd_hit !== 1'b0 || fwd_rdata !== 32'd0) begin
            fails++; $display("FAIL fwd_r0: hit=%b d=%h want 0 0", fwd_hit, fwd_rdata); end
        fwd_raddr = 5'd6; #1;
        tests++; if (fwd_hit !== 1'b0 || fwd_rdata !== 32'd0) begin
            fails++; $display("FAIL fwd_miss: hit=%b d=%h want 0 0", fwd_hit, fwd_rdata); end
        rf_hold = 1'b0;
        tick(); tick();
    endtask

    task automatic test_hilo();
        logic [31:0] lo_before;
        lo_before = m_lo;
        rf_hold = 1'b1;
        drive(1'b1, 32'h300, 1'b0, 5'd0, 32'd0, 1'b1, 32'h77, 1'b0, 32'h99);
        tick();
        idle_in();
        #1;
        tests++; if (fwd_hi !== 32'h77 || fwd_lo !== lo_before || hi_q !== 32'd0) begin
            fails++; $display("FAIL hilo_bypass: fhi=%h flo=%h hi=%h want 77 %h 0", fwd_hi, fwd_lo, hi_q, lo_before); end
        rf_hold = 1'b0;
        #1;
        tests++; if (fwd_hi !== 32'h77) begin
            fails++; $display("FAIL hilo_bypass_retiring: fhi=%h want 77", fwd_hi); end
        tick();
        tests++; if (hi_q !== 32'h77 || lo_q !== lo_before) begin
            fails++; $display("FAIL hilo_commit: hi=%h lo=%h want 77 %h", hi_q, lo_q, lo_before); end
    endtask

    task automatic test_r0();
        logic [31:0] cnt_before;
        cnt_before = m_cnt;
        drive(1'b1, 32'h400, 1'b1, 5'd0, 32'hFF, 1'b0, 32'd0, 1'b0, 32'd0);
        tick();
        idle_in();
        #1;
        tests++; if (rf_we !== 1'b0 || dbg_wen !== 4'd0 || dbg_pc !== 32'h400) begin
            fails++; $display("FAIL r0_suppress: we=%b wen=%h pc=%h want 0 0 400", rf_we, dbg_wen, dbg_pc); end
        tick();
        tests++; if (retire_cnt !== cnt_before + 32'd1) begin
            fails++; $display("FAIL r0_count: cnt=%0d want %0d", retire_cnt, cnt_before + 32'd1); end
    endtask

    task automatic test_flush();
        logic [31:0] cnt_before, hi_before;
        cnt_before = m_cnt;
        hi_before  = m_hi;
        rf_hold = 1'b1;
        drive(1'b1, 32'h500, 1'b1, 5'd7, 32'h55, 1'b1, 32'hDEAD, 1'b0, 32'd0); tick();
        drive(1'b1, 32'h504, 1'b1, 5'd8, 32'h66, 1'b0, 32'd0, 1'b0, 32'd0); tick();
        rf_hold = 1'b0;
        flush = 1'b1;
        drive(1'b1, 32'h508, 1'b1, 5'd9, 32'h77, 1'b1, 32'hBEEF, 1'b0, 32'd0);
        #1;
        tests++; if (rf_we !== 1'b0 || dbg_pc !== 32'd0 || in_ready !== 1'b0) begin
            fails++; $display("FAIL flush_cycle: we=%b pc=%h ready=%b want 0 0 0", rf_we, dbg_pc, in_ready); end
        tick();
        flush = 1'b0;
        idle_in();
        #1;
        tests++; if (occupancy !== 2'd0 || rf_we !== 1'b0 || dbg_pc !== 32'd0) begin
            fails++; $display("FAIL flush_empty: occ=%0d we=%b pc=%h want 0 0 0", occupancy, rf_we, dbg_pc); end
        tests++; if (retire_cnt !== cnt_before || hi_q !== hi_before) begin
            fails++; $display("FAIL flush_hold: cnt=%0d hi=%h want %0d %h", retire_cnt, hi_q, cnt_before, hi_before); end
    endtask

    task automatic test_random();
        logic        hit;
        logic [31:0] data;
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            rf_hold   = ($urandom_range(0, 2) == 0);
            fwd_raddr = 5'($urandom_range(0, 3));
            drive($urandom_range(0, 3) != 0, $urandom, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), $urandom);
            #1;
            if (!rst) begin
                data = m_fwd_rdata(fwd_raddr, hit);
                tests++; if (in_ready !== ((q.size() < DEPTH) && !flush)) begin
                    fails++; $display("FAIL rnd_ready c%0d: got %b", c, in_ready); end
                tests++; if (occupancy !== 2'(q.size())) begin
                    fails++; $display("FAIL rnd_occ c%0d: got %0d want %0d", c, occupancy, q.size()); end
                tests++; if (rf_we !== m_rf_we() || dbg_wen !== {4{m_rf_we()}}) begin
                    fails++; $display("FAIL rnd_we c%0d: got %b/%h want %b", c, rf_we, dbg_wen, m_rf_we()); end
                tests++; if (m_retire() ? (rf_waddr !== q[0].waddr || rf_wdata !== q[0].wdata ||
                                           dbg_pc !== q[0].pc)
                                        : (rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || dbg_pc !== 32'd0)) begin
                    fails++; $display("FAIL rnd_head c%0d: a=%0d d=%h pc=%h", c, rf_waddr, rf_wdata, dbg_pc); end
                tests++; if (fwd_hit !== hit || fwd_rdata !== data) begin
                    fails++; $display("FAIL rnd_fwd c%0d: got %b/%h want %b/%h", c, fwd_hit, fwd_rdata, hit, data); end
                tests++; if (fwd_hi !== m_fwd_hi() || fwd_lo !== m_fwd_lo()) begin
                    fails++; $display("FAIL rnd_fwd_hilo c%0d: got %h/%h want %h/%h", c, fwd_hi, fwd_lo,
                                      m_fwd_hi(), m_fwd_lo()); end
                tests++; if (hi_q !== m_hi || lo_q !== m_lo || retire_cnt !== m_cnt) begin
                    fails++; $display("FAIL rnd_regs c%0d: got %h/%h/%0d want %h/%h/%0d", c, hi_q, lo_q,
                                      retire_cnt, m_hi, m_lo, m_cnt); end
            end
            tick();
        end
        rst = 1'b0; flush = 1'b0; rf_hold = 1'b0;
        idle_in();
    endtask

    initial begin
        m_hi = 0; m_lo = 0; m_cnt = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_fwd();
        test_hilo();
        test_r0();
        test_flush();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wb_retire_queue.md
# wb_retire_queue

Parametrised writeback/retire stage between MEM and the register file. It replaces the single-entry stall-driven writeback register with a DEPTH-entry in-order retire queue that has a valid/ready handshake and flush. It also commits architectural HI/LO registers and exposes a youngest-match bypass lookup to ID over all queued writes. Debug trace outputs and a retire counter are driven from the retiring entry.

## Interface
- DATA_W, 32, GPR/HI/LO data width
- ADDR_W, 5, GPR address width
- PC_W, 32, PC width
- DEPTH, 2, queue entries; power of two, ≥2
- clk  in  1  clock, rising edge
- rst  in  1  reset rst, synchronous, active-high
- flush  in  1  synchronous discard of all queued entries
- in_valid  in  1  MEM presents an entry
- in_ready  out  1  queue can accept
- in_pc  in  PC_W  entry PC
- in_rf_we / in_rf_waddr / in_rf_wdata  in  1 / ADDR_W / DATA_W  GPR write
- in_hi_we / in_hi_wdata, in_lo_we / in_lo_wdata  in  1 / DATA_W  HI/LO write
- rf_hold  in  1  sink backpressure; head must not retire
- rf_we / rf_waddr / rf_wdata  out  1 / ADDR_W / DATA_W  register-file write port
- hi_q, lo_q  out  DATA_W  architectural HI/LO
- fwd_raddr  in  ADDR_W  bypass lookup address
- fwd_hit / fwd_rdata  out  1 / DATA_W  youngest queued write to fwd_raddr
- fwd_hi, fwd_lo  out  DATA_W  youngest queued HI/LO value, else hi_q/lo_q
- debug_wb_pc / debug_wb_rf_wen / debug_wb_rf_wnum / debug_wb_rf_wdata  out  PC_W / 4 / ADDR_W / DATA_W  trace
- retire_cnt  out  32  retired-entry count
- occupancy  out  log2(DEPTH)+1  queued entries

## Operation
- Storage: circular buffer with wr_ptr, rd_ptr, and count, all registered. Entry fields: pc, rf_we, waddr, wdata, hi_we, hi_wdata, lo_we, lo_wdata.
- Readiness: in_ready = (count < DEPTH) && !flush. There is no pass-through when full, even if the head retires in the same cycle.
- Accept: in_valid && in_ready writes the entry at wr_ptr. wr_ptr advances and wraps at DEPTH.
- Retire: retire = (count != 0) && !rf_hold && !flush.
  - rd_ptr advances on retire.
  - count updates by +accept −retire. Simultaneous accept and retire leaves count unchanged.
- Outputs when retire is high:
  - rf_we = head.rf_we && head.waddr != 0. Writes to r0 are suppressed.
  - rf_waddr and rf_wdata come from the head.
  - debug_wb_pc = head.pc; debug_wb_rf_wen = {4{rf_we}}; wnum and wdata mirror rf_waddr and rf_wdata.
- Outputs when retire is low: all retire and debug outputs are 0.
- HI/LO: on a retiring edge, hi_q ← head.hi_wdata if head.hi_we, and lo_q ← head.lo_wdata if head.lo_we.
- GPR bypass (combinational) searches queued entries only (count entries from rd_ptr).
  - fwd_hit = 1 for the youngest entry with rf_we && waddr == fwd_raddr; fwd_rdata is that entry's wdata.
  - fwd_raddr = 0 never hits; fwd_hit = 0 gives fwd_rdata = 0.
  - The input entry of the current cycle is not visible to the lookup.
- HI/LO bypass: fwd_hi and fwd_lo are the youngest queued hi_we/lo_we data, else hi_q/lo_q. The bypass includes the head even while it is retiring.
- Retire counter: retire_cnt increments by 1 per retire, including entries with no writes, and wraps at 2^32.
- Flush:
  - Next edge: count, rd_ptr, and wr_ptr are set to 0.
  - In the flush cycle: nothing retires, nothing is accepted, and HI/LO and retire_cnt hold.
- Reset: count, pointers, hi_q, lo_q, and retire_cnt are all 0.
  - All outputs are 0 except in_ready = 1 from the first cycle after reset.
  - Queued entries are lost on reset mid-operation.

## Timing
- Latency: an entry accepted at edge N into an empty queue drives the rf/debug outputs during cycle N+1 (if rf_hold = 0) and leaves at edge N+1.
- HI/LO visibility: hi_q/lo_q show the committed value from the cycle after the retiring edge.
- Throughput: one accept and one retire per cycle, sustained with count constant.
- rf_hold stalls the head indefinitely. The outputs are 0 while held, and the head is unchanged.
- Combinational paths:
  - in_ready depends on count and flush only.
  - fwd_* depend on fwd_raddr and registered state only.
  - Retire outputs depend on registered state, rf_hold, and flush.

## Test plan
- Reset, then push pc=0xBFC00000 with rf_we=1, r3, 0x1234 and no hold: rf_we=1 and waddr=3 in the next cycle, debug_wb_rf_wen=4'hF, retire_cnt=1.
- With DEPTH=2, hold rf_hold=1 and push 3 entries: in_ready=0 after 2 accepts and occupancy=2. Release hold: entries retire in order on consecutive cycles and in_ready returns to 1.
- Queue r5=0xA then r5=0xB, with rf_hold=1 and fwd_raddr=5: fwd_hit=1, fwd_rdata=0xB. fwd_raddr=0 or 6 gives fwd_hit=0.
- Push an entry with hi_we=1 (0x77) and lo_we=0: fwd_hi=0x77 while queued; hi_q=0x77 after retire; lo_q unchanged.
- Push r0 with wdata=0xFF: rf_we=0 and debug_wb_rf_wen=0, but retire_cnt increments.
- Flush with 2 entries queued and in_valid=1: no retire in that cycle; next cycle occupancy=0, the input entry is dropped, and retire_cnt and hi_q are unchanged.
